// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp codes and sequencer state type shared by the traffic-light sequencer files.
package traffic_pkg;
  localparam logic [2:0] LT_OFF    = 3'b000;
  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_GREEN  = 3'b010;
  localparam logic [2:0] LT_YELLOW = 3'b001;
  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} tl_state_t;
endpackage

// File: rtl/traffic_seq_ctrl_phase_timer.sv
// phase_timer: loadable down-counter that stops at zero and flags expiry.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count,
  output logic             o_expired
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (!o_expired) r_cnt <= r_cnt - CNT_W'(1);
  end
  assign o_count   = r_cnt;
  assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/traffic_seq_ctrl.sv
// traffic_seq_ctrl: round-robin N_CH-approach traffic-light sequencer with programmable phase lengths.
// Define TL_ALLRED_EN to insert the all-red clearance phase between YELLOW and the next GREEN.
module traffic_seq_ctrl
  import traffic_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CNT_W = 8,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  green_time,
  input  logic [CNT_W-1:0]  yellow_time,
  input  logic [CNT_W-1:0]  allred_time,
  output logic [3*N_CH-1:0] lights,
  output logic [CH_W-1:0]   cur_ch,
  output logic              phase_done,
  output logic              cycle_wrap
);
  tl_state_t         r_state, w_step, w_nxt_state;
  logic [CH_W-1:0]   r_ch, w_ch_inc, w_nxt_ch;
  logic [CNT_W-1:0]  w_cnt, w_dur, w_ld_val, w_nxt_cnt;
  logic [3*N_CH-1:0] r_lights, w_lights;
  logic              r_done, r_wrap, w_exp, w_load;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_ld_val),
    .o_count    (w_cnt),
    .o_expired  (w_exp)
  );

`ifdef TL_ALLRED_EN
  assign w_step = (r_state == GREEN) ? YELLOW : (r_state == YELLOW) ? ALLRED : GREEN;
  assign w_dur  = (w_nxt_state == GREEN) ? green_time : (w_nxt_state == YELLOW) ? yellow_time :
                  (w_nxt_state == ALLRED) ? allred_time : '0;
`else
  logic w_unused_allred;
  assign w_unused_allred = ^allred_time;
  assign w_step = (r_state == GREEN) ? YELLOW : GREEN;
  assign w_dur  = (w_nxt_state == GREEN) ? green_time : (w_nxt_state == YELLOW) ? yellow_time : '0;
`endif

  assign w_ch_inc    = (r_ch == CH_W'(N_CH - 1)) ? '0 : r_ch + CH_W'(1);
  assign w_nxt_state = !en ? IDLE : (r_state == IDLE) ? GREEN : w_exp ? w_step : r_state;
  assign w_nxt_ch    = (!en || r_state == IDLE) ? '0 : (w_exp && w_step == GREEN) ? w_ch_inc : r_ch;
  // Every phase entry (and every idle cycle) reloads the timer, so durations are sampled only here.
  assign w_load      = !en || (r_state == IDLE) || w_exp;
  assign w_ld_val    = (w_dur == '0) ? '0 : w_dur - CNT_W'(1);
  assign w_nxt_cnt   = w_load ? w_ld_val : (w_exp ? '0 : w_cnt - CNT_W'(1));

  always_comb begin
    w_lights = '0;
    for (int i = 0; i < N_CH; i++)
      w_lights[3*i +: 3] = (w_nxt_state == IDLE) ? LT_OFF :
                           (w_nxt_state == ALLRED || CH_W'(i) != w_nxt_ch) ? LT_RED :
                           (w_nxt_state == GREEN) ? LT_GREEN : LT_YELLOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ch     <= '0;
      r_lights <= '0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_ch     <= w_nxt_ch;
      r_lights <= w_lights;
      r_done   <= (w_nxt_state != IDLE) && (w_nxt_cnt == '0);
      r_wrap   <= w_load && (w_nxt_state == GREEN) && (w_nxt_ch == '0);
    end
  end

  assign lights     = r_lights;
  assign cur_ch     = r_ch;
  assign phase_done = r_done;
  assign cycle_wrap = r_wrap;
endmodule

// File: doc/traffic_seq_ctrl.md
# traffic_seq_ctrl

Parametrised multi-approach traffic-light sequencer: drives N_CH approaches round-robin through green, yellow and optional all-red clearance, with runtime-programmable phase durations. It replaces the fixed two-approach state-to-light decoder. It owns its own phase timer and state register, and sits between the system enable/config registers and the lamp drivers.

## Interface
- N_CH, default 2: number of approaches (legal range 2..8).
- CNT_W, default 8: width of duration inputs and of the phase timer.
- CH_W, default $clog2(N_CH): width of cur_ch.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous reset, active-low.
- en  in  1  run enable. Low forces IDLE.
- green_time  in  CNT_W  green duration in cycles.
- yellow_time  in  CNT_W  yellow duration in cycles.
- allred_time  in  CNT_W  all-red clearance duration in cycles. Ignored when the feature is compiled out.
- lights  out  3*N_CH  per-approach lamp code. Approach i occupies lights[3*i +: 3].
- cur_ch  out  CH_W  approach currently holding right-of-way.
- phase_done  out  1  one-cycle pulse on the last cycle of each GREEN/YELLOW/ALLRED phase.
- cycle_wrap  out  1  one-cycle pulse on the first cycle of GREEN for approach 0.

## Operation
- Lamp codes: OFF=3'b000, RED=3'b100, GREEN=3'b010, YELLOW=3'b001.
- States:
  - IDLE: all lamps OFF.
  - GREEN: cur_ch shows GREEN, all other approaches RED.
  - YELLOW: cur_ch shows YELLOW, all other approaches RED.
  - ALLRED: all approaches RED.
- Transitions:
  - IDLE → GREEN(ch 0) when en=1.
  - GREEN → YELLOW when the timer expires.
  - YELLOW → ALLRED when the timer expires.
  - ALLRED → GREEN(ch+1) when the timer expires.
  - The channel index wraps from N_CH-1 to 0.
- Any state → IDLE on the cycle after en=0, regardless of the timer. Re-enabling always restarts at ch 0.
- Timer behaviour:
  - On entry to each phase, the timer loads max(dur,1)-1, where dur is the matching *_time input.
  - The timer decrements once per cycle and expires when it equals 0.
  - A duration of 0 behaves as 1.
- Durations are sampled only at phase entry. Changes during a phase take effect from the next phase.
- All outputs are registered. No combinational path exists from any input to any output.

## Timing
- Reset values: state IDLE, lights all 0, cur_ch 0, timer 0, phase_done 0, cycle_wrap 0.
- Reset asserts asynchronously and releases synchronously to clk.
- en rising, sampled at edge k → GREEN for ch 0 visible after edge k+1. cycle_wrap is high for that one cycle.
- Each phase lasts exactly max(dur,1) cycles. phase_done is high during the final cycle of the phase.
- Full period = N_CH × (G + Y + A) cycles, where each term is max(dur,1). A = 0 when the feature is off.
- en=0 during the final cycle of a phase: IDLE wins, and no following phase starts. phase_done still pulses that cycle.

## Configuration
- The macro TL_ALLRED_EN compiles in the ALLRED state.
- Defined: YELLOW → ALLRED → GREEN(ch+1).
- Undefined:
  - YELLOW → GREEN(ch+1) directly.
  - ALLRED state and its logic are absent.
  - allred_time port remains and is unused, so the interface stays stable.

## Structure
- Shared package traffic_pkg holds:
  - lamp code localparams LT_OFF, LT_RED, LT_GREEN, LT_YELLOW;
  - state enum tl_state_t (IDLE, GREEN, YELLOW, ALLRED).
- One sub-module, phase_timer: a CNT_W loadable down-counter with load, load value, expired flag, and clk/rst_n.
- The sequencer FSM and per-channel lamp encoding live in traffic_seq_ctrl.

## Test plan
All scenarios use N_CH=2, green=3, yellow=2, allred=1, TL_ALLRED_EN defined, unless stated otherwise.

1. Reset: hold rst_n=0 mid-GREEN → lights=6'b000000, cur_ch=0, pulses 0, asynchronously without a clock edge.
2. en raised at edge 0 → sequence:
   - cycles 1–3: lights=6'b100_010;
   - cycles 4–5: lights=6'b100_001;
   - cycle 6: lights=6'b100_100;
   - cycles 7–9: lights=6'b010_100, cur_ch=1.
3. Wrap: continue from scenario 2 → ch 0 GREEN resumes at cycle 13 with cycle_wrap=1 for one cycle. Period is 12 cycles, and phase_done pulses 6 times per period.
4. Zero durations: green=0, yellow=0, allred=0 → each phase lasts 1 cycle. Period is 6; phase_done is high every cycle.
5. Mid-operation disable: en=0 during the second YELLOW cycle → lights=0 and IDLE on the next cycle. Re-enable → restarts at ch 0 GREEN.
6. Macro undefined: same stimulus as scenario 2 → ch 1 GREEN at cycle 6, and no all-RED cycle ever appears. Period is 10.
7. Mid-phase reprogram: change green_time from 3 to 5 during ch 0 GREEN → current green stays 3 cycles, and ch 1 GREEN lasts 5.
